// File: rtl/ascii_number_parser_if.sv
// Handshake bundle between a byte source, the ASCII number parser and a value consumer.
// The master drives characters in and accepts results; the slave is the parser.
interface ascii_number_parser_if #(
   parameter int unsigned DW = 32
);
   logic          rx_vld;
   logic [7:0]    rx_dat;
   logic          rx_rdy;
   logic          res_vld;
   logic [DW-1:0] res_dat;
   logic          res_ovf;
   logic          res_err;
   logic          res_rdy;

   modport master (
      output rx_vld, rx_dat, res_rdy,
      input  rx_rdy, res_vld, res_dat, res_ovf, res_err
   );

   modport slave (
      input  rx_vld, rx_dat, res_rdy,
      output rx_rdy, res_vld, res_dat, res_ovf, res_err
   );
endinterface

// File: rtl/ascii_number_parser.sv
// Streaming ASCII decimal / 0x-hex number parser: one character per accepted byte,
// one registered result per terminated token.
module ascii_number_parser #(
   parameter int unsigned DW = 32
) (
   input logic                  clk,
   input logic                  rst,
   ascii_number_parser_if.slave bus
);
   localparam int unsigned WW = DW + 4;
   localparam logic [DW-1:0] MIN_MAG = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_SIGN, S_ZERO, S_HEXPRE, S_DEC, S_HEX, S_SKIP, S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] acc_q, acc_d;
   logic          ovf_q, ovf_d;
   logic          neg_q, neg_d;
   logic          rx_rdy_q;
   logic          res_vld_q;
   logic [DW-1:0] res_dat_q;
   logic          res_ovf_q;
   logic          res_err_q;

   logic          take_c, is_term_c, is_dec_c, is_hex_c, is_x_c, is_minus_c;
   logic [3:0]    digit_c;
   logic [WW-1:0] dec_wide_c;
   logic [DW-1:0] dec_acc_c, hex_acc_c, fin_dat_c;
   logic          dec_ovf_c, hex_ovf_c, fin_ovf_c;
   logic          done_c, err_c;

   // Character classification and candidate accumulator updates
   always_comb begin
      take_c     = bus.rx_vld && rx_rdy_q;
      is_term_c  = (bus.rx_dat == 8'h00) || (bus.rx_dat == 8'h0A) ||
                   (bus.rx_dat == 8'h0D) || (bus.rx_dat == 8'h20);
      is_dec_c   = (bus.rx_dat >= 8'h30) && (bus.rx_dat <= 8'h39);
      is_hex_c   = is_dec_c ||
                   ((bus.rx_dat >= 8'h61) && (bus.rx_dat <= 8'h66)) ||
                   ((bus.rx_dat >= 8'h41) && (bus.rx_dat <= 8'h46));
      is_x_c     = (bus.rx_dat == 8'h78) || (bus.rx_dat == 8'h58);
      is_minus_c = (bus.rx_dat == 8'h2D);
      digit_c    = is_dec_c ? bus.rx_dat[3:0] : 4'(bus.rx_dat[3:0] + 4'd9);
      dec_wide_c = WW'(acc_q) * WW'(10) + WW'(digit_c);
      dec_acc_c  = dec_wide_c[DW-1:0];
      dec_ovf_c  = ovf_q | (|dec_wide_c[WW-1:DW]);
      hex_acc_c  = {acc_q[DW-5:0], digit_c};
      hex_ovf_c  = ovf_q | (|acc_q[DW-1:DW-4]);
      fin_dat_c  = neg_q ? (~acc_q + DW'(1)) : acc_q;
      fin_ovf_c  = ovf_q | (neg_q && (acc_q > MIN_MAG));
   end

   // Next-state and token bookkeeping
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      neg_d   = neg_q;
      done_c  = 1'b0;
      err_c   = 1'b0;
      case (state_q)
         S_IDLE: if (take_c && !is_term_c) begin
            if (is_minus_c) begin
               neg_d   = 1'b1;
               state_d = S_SIGN;
            end else if (bus.rx_dat == 8'h30) begin
               state_d = S_ZERO;
            end else if (is_dec_c) begin
               acc_d   = dec_acc_c;
               ovf_d   = dec_ovf_c;
               state_d = S_DEC;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_SIGN: if (take_c) begin
            if (is_dec_c) begin
               acc_d   = dec_acc_c;
               ovf_d   = dec_ovf_c;
               state_d = S_DEC;
            end else if (is_term_c) begin
               done_c = 1'b1;
               err_c  = 1'b1;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_ZERO: if (take_c) begin
            if (is_x_c) begin
               state_d = neg_q ? S_SKIP : S_HEXPRE;
            end else if (is_dec_c) begin
               acc_d   = dec_acc_c;
               ovf_d   = dec_ovf_c;
               state_d = S_DEC;
            end else if (is_term_c) begin
               done_c = 1'b1;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_HEXPRE: if (take_c) begin
            if (is_hex_c) begin
               acc_d   = hex_acc_c;
               ovf_d   = hex_ovf_c;
               state_d = S_HEX;
            end else if (is_term_c) begin
               done_c = 1'b1;
               err_c  = 1'b1;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_DEC: if (take_c) begin
            if (is_dec_c) begin
               acc_d = dec_acc_c;
               ovf_d = dec_ovf_c;
            end else if (is_term_c) begin
               done_c = 1'b1;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_HEX: if (take_c) begin
            if (is_hex_c) begin
               acc_d = hex_acc_c;
               ovf_d = hex_ovf_c;
            end else if (is_term_c) begin
               done_c = 1'b1;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_SKIP: if (take_c && is_term_c) begin
            done_c = 1'b1;
            err_c  = 1'b1;
         end
         S_DONE: if (bus.res_rdy) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            neg_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (done_c) state_d = S_DONE;
   end

   // State and registered outputs; the result is latched on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         neg_q     <= 1'b0;
         rx_rdy_q  <= 1'b0;
         res_vld_q <= 1'b0;
         res_dat_q <= '0;
         res_ovf_q <= 1'b0;
         res_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
         neg_q    <= neg_d;
         rx_rdy_q <= (state_d != S_DONE);
         if (done_c) begin
            res_vld_q <= 1'b1;
            res_err_q <= err_c;
            res_dat_q <= err_c ? '0 : fin_dat_c;
            res_ovf_q <= err_c ? 1'b0 : fin_ovf_c;
         end else if (state_q == S_DONE && bus.res_rdy) begin
            res_vld_q <= 1'b0;
         end
      end
   end

   assign bus.rx_rdy  = rx_rdy_q;
   assign bus.res_vld = res_vld_q;
   assign bus.res_dat = res_dat_q;
   assign bus.res_ovf = res_ovf_q;
   assign bus.res_err = res_err_q;
endmodule

// File: tb/tb_ascii_number_parser.sv
// Bench for ascii_number_parser: directed vector table, handshake corner sequences,
// and random token streams scored against a token-level reference model.
module tb_ascii_number_parser;
   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [31:0] dat;
      logic        ovf;
      logic        err;
   } exp_t;

   typedef struct {
      string      txt;
      logic [7:0] term;
      exp_t       e;
   } vec_t;

   logic clk;
   logic rst;
   ascii_number_parser_if #(.DW(DW)) bus ();

   ascii_number_parser #(.DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];
   vec_t       vecs[$];
   logic [7:0] tok_q[$];
   bit         rand_busy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic bit tb_is_dec(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic bit tb_is_hex(input logic [7:0] c);
      return tb_is_dec(c) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
   endfunction

   function automatic int tb_hex_val(input logic [7:0] c);
      if (tb_is_dec(c)) return int'(c) - 48;
      if (c >= 8'h61) return int'(c) - 87;
      return int'(c) - 55;
   endfunction

   // Token-level reference: a token is either -?[0-9]+ or 0[xX][0-9a-fA-F]+
   function automatic exp_t model(input logic [7:0] t[$]);
      exp_t         e;
      logic [127:0] mag;
      logic [127:0] negv;
      bit           neg;
      bit           ok;
      int           i;
      mag = '0;
      neg = 1'b0;
      ok  = 1'b1;
      i   = 0;
      if (t.size() > 0 && t[0] == 8'h2D) begin
         neg = 1'b1;
         i   = 1;
      end
      if (!neg && t.size() >= 3 && t[0] == 8'h30 && (t[1] == 8'h78 || t[1] == 8'h58)) begin
         for (int k = 2; k < t.size(); k++) begin
            if (tb_is_hex(t[k])) mag = mag * 16 + 128'(tb_hex_val(t[k]));
            else ok = 1'b0;
         end
      end else begin
         if (t.size() <= i) ok = 1'b0;
         for (int k = i; k < t.size(); k++) begin
            if (tb_is_dec(t[k])) mag = mag * 10 + 128'(tb_hex_val(t[k]));
            else ok = 1'b0;
         end
      end
      if (!ok) begin
         e.dat = '0;
         e.ovf = 1'b0;
         e.err = 1'b1;
      end else begin
         negv  = 128'd0 - mag;
         e.err = 1'b0;
         e.ovf = neg ? (mag > 128'h8000_0000) : (mag > 128'hFFFF_FFFF);
         e.dat = neg ? negv[31:0] : mag[31:0];
      end
      return e;
   endfunction

   task automatic add_vec(input string t, input logic [7:0] term, input logic [31:0] d,
                          input logic o, input logic er);
      vec_t v;
      v.txt   = t;
      v.term  = term;
      v.e.dat = d;
      v.e.ovf = o;
      v.e.err = er;
      vecs.push_back(v);
   endtask

   // Present one byte and return 1ns after the edge that consumed it
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_vld = 1'b1;
      bus.rx_dat = b;
      while (1) begin
         @(negedge clk);
         if (bus.rx_rdy === 1'b1) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL rx_rdy_timeout: byte 0x%0h not accepted within %0d cycles", b, n);
            bus.rx_vld = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s);
      for (int k = 0; k < s.len(); k++) send_byte(s[k]);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Result monitor: scoreboard on every transfer, stability while stalled
   initial begin : monitor
      exp_t e;
      bit   hold_prev;
      exp_t prev;
      hold_prev = 1'b0;
      prev      = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               check("hold_vld", 64'(bus.res_vld), 64'd1);
               check("hold_res", 64'({bus.res_dat, bus.res_ovf, bus.res_err}), 64'(prev));
            end
            if (bus.res_vld && bus.res_rdy) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got dat 0x%0h err %0d, required no result",
                           bus.res_dat, bus.res_err);
               end else begin
                  e = exp_q.pop_front();
                  check("res_dat", 64'(bus.res_dat), 64'(e.dat));
                  check("res_ovf", 64'(bus.res_ovf), 64'(e.ovf));
                  check("res_err", 64'(bus.res_err), 64'(e.err));
               end
            end
            hold_prev = bus.res_vld && !bus.res_rdy;
            prev      = {bus.res_dat, bus.res_ovf, bus.res_err};
         end
      end
   end

   task automatic gen_token();
      string pool;
      string hx;
      int    kind;
      int    n;
      pool = "0123456789abcdefxX-gz+.AF";
      hx   = "0123456789abcdefABCDEF";
      tok_q.delete();
      kind = $urandom_range(0, 3);
      case (kind)
         0: begin
            if ($urandom_range(0, 1) == 1) tok_q.push_back(8'h2D);
            n = $urandom_range(1, 12);
            repeat (n) tok_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
         end
         1: begin
            tok_q.push_back(8'h30);
            tok_q.push_back(($urandom_range(0, 1) == 1) ? 8'h58 : 8'h78);
            n = $urandom_range(1, 10);
            repeat (n) tok_q.push_back(hx[$urandom_range(0, hx.len() - 1)]);
         end
         2: begin
            n = $urandom_range(1, 6);
            repeat (n) tok_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
         end
         default: begin
            tok_q.push_back(8'h30);
            n = $urandom_range(0, 3);
            repeat (n) tok_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
         end
      endcase
   endtask

   function automatic logic [7:0] rand_term();
      logic [7:0] terms[4];
      terms = '{8'h00, 8'h0A, 8'h0D, 8'h20};
      return terms[$urandom_range(0, 3)];
   endfunction

   initial begin : watchdog
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      rst         = 1'b1;
      bus.rx_vld  = 1'b0;
      bus.rx_dat  = 8'h00;
      bus.res_rdy = 1'b1;
      rand_busy   = 1'b0;

      add_vec("1234",        8'h20, 32'h0000_04D2, 1'b0, 1'b0);
      add_vec("0xDeadBeef",  8'h0A, 32'hDEAD_BEEF, 1'b0, 1'b0);
      add_vec("-42",         8'h00, 32'hFFFF_FFD6, 1'b0, 1'b0);
      add_vec("-0x10",       8'h20, 32'h0000_0000, 1'b0, 1'b1);
      add_vec("4294967296",  8'h20, 32'h0000_0000, 1'b1, 1'b0);
      add_vec("0x1FFFFFFFF", 8'h20, 32'hFFFF_FFFF, 1'b1, 1'b0);
      add_vec("-2147483648", 8'h20, 32'h8000_0000, 1'b0, 1'b0);
      add_vec("-2147483649", 8'h20, 32'h7FFF_FFFF, 1'b1, 1'b0);
      add_vec("12a4",        8'h20, 32'h0000_0000, 1'b0, 1'b1);
      add_vec("  7",         8'h0D, 32'h0000_0007, 1'b0, 1'b0);
      add_vec("0",           8'h20, 32'h0000_0000, 1'b0, 1'b0);
      add_vec("0x",          8'h20, 32'h0000_0000, 1'b0, 1'b1);
      add_vec("-",           8'h20, 32'h0000_0000, 1'b0, 1'b1);
      add_vec("0X7f",        8'h0A, 32'h0000_007F, 1'b0, 1'b0);
      add_vec("007",         8'h20, 32'h0000_0007, 1'b0, 1'b0);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rx_rdy",  64'(bus.rx_rdy),  64'd0);
      check("rst_res_vld", 64'(bus.res_vld), 64'd0);
      check("rst_res_dat", 64'(bus.res_dat), 64'd0);
      check("rst_res_ovf", 64'(bus.res_ovf), 64'd0);
      check("rst_res_err", 64'(bus.res_err), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_rx_rdy", 64'(bus.rx_rdy), 64'd1);
      @(posedge clk);
      #1;

      // Latency: result one cycle after the terminator, single pulse
      exp_q.push_back('{32'h0000_04D2, 1'b0, 1'b0});
      send_str("1234");
      send_byte(8'h20);
      bus.rx_vld = 1'b0;
      @(negedge clk);
      check("lat_res_vld", 64'(bus.res_vld), 64'd1);
      check("lat_rx_rdy",  64'(bus.rx_rdy),  64'd0);
      @(posedge clk);
      @(negedge clk);
      check("pulse_res_vld", 64'(bus.res_vld), 64'd0);
      check("pulse_rx_rdy",  64'(bus.rx_rdy),  64'd1);
      @(posedge clk);
      #1;
      wait_drain(5);

      // Directed vector table at full rate
      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i].e);
         send_str(vecs[i].txt);
         send_byte(vecs[i].term);
         bus.rx_vld = 1'b0;
         wait_drain(10);
      end

      // Backpressure: result held, input stalled, then one transfer
      exp_q.push_back('{32'd99, 1'b0, 1'b0});
      bus.res_rdy = 1'b0;
      send_str("99 ");
      bus.rx_vld = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_rx_rdy",  64'(bus.rx_rdy),  64'd0);
         check("bp_res_vld", 64'(bus.res_vld), 64'd1);
         check("bp_res_dat", 64'(bus.res_dat), 64'd99);
      end
      @(posedge clk);
      #1 bus.res_rdy = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("bp_after_vld",    64'(bus.res_vld), 64'd0);
      check("bp_after_rx_rdy", 64'(bus.rx_rdy),  64'd1);
      @(posedge clk);
      #1;
      wait_drain(5);

      // Reset mid-token abandons it
      send_str("98");
      bus.rx_vld = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_rx_rdy",  64'(bus.rx_rdy),  64'd0);
      check("midrst_res_vld", 64'(bus.res_vld), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.push_back('{32'd5, 1'b0, 1'b0});
      send_str("5 ");
      bus.rx_vld = 1'b0;
      wait_drain(10);

      // Random token stream with input gaps and random backpressure
      rand_busy = 1'b1;
      fork
         begin
            for (int t = 0; t < 400; t++) begin
               gen_token();
               exp_q.push_back(model(tok_q));
               repeat ($urandom_range(0, 2)) send_byte(rand_term());
               for (int k = 0; k < tok_q.size(); k++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     bus.rx_vld = 1'b0;
                     bus.rx_dat = 8'($urandom);
                     repeat ($urandom_range(1, 3)) @(posedge clk);
                     #1;
                  end
                  send_byte(tok_q[k]);
               end
               send_byte(rand_term());
            end
            bus.rx_vld = 1'b0;
            rand_busy  = 1'b0;
         end
         begin
            while (rand_busy) begin
               @(posedge clk);
               #1 bus.res_rdy = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.res_rdy = 1'b1;
      wait_drain(50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ascii_number_parser.md
# ascii_number_parser

Streaming parser that converts ASCII decimal or hexadecimal number text into a packed integer, one character per accepted byte. It is the reverse of integer-to-string formatting: text produced by `$swrite`-style formatting, or stored as packed byte arrays, is turned back into a numeric value. It sits between a byte source, such as a UART receive path or a string ROM reader, and a consumer expecting binary values. It uses valid/ready handshakes on both sides.

## Interface

Parameters:
- DW, 32, result width in bits (≥ 8).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- rx_vld  input  1  input character valid.
- rx_dat  input  8  ASCII character.
- rx_rdy  output  1  parser can accept a character.
- res_vld  output  1  result valid.
- res_dat  output  DW  parsed value, two's complement if negative.
- res_ovf  output  1  result overflowed DW bits (value is truncated modulo 2^DW).
- res_err  output  1  malformed token (res_dat = 0).
- res_rdy  input  1  consumer accepts the result.

## Operation

- Character classes:
  - Terminator: 0x00, 0x0A, 0x0D, 0x20.
  - Decimal digit: '0'–'9'.
  - Hex digit: '0'–'9', 'a'–'f', 'A'–'F' (case-insensitive).
  - Sign: '-'.
  - Prefix: 'x' or 'X', allowed only directly after a leading '0'.
  - Any other byte is invalid.
- A byte is consumed when rx_vld && rx_rdy.
- FSM states and transitions:
  - IDLE: terminators are skipped. '-' → SIGN. '0' → ZERO. '1'–'9' → DEC. Other → SKIP.
  - SIGN: decimal digit → DEC. Other non-terminator → SKIP. Terminator → DONE with error.
  - ZERO: 'x'/'X' → HEXPRE, but only if not negative; a negative goes to SKIP. Decimal digit → DEC. Terminator → DONE with value 0. Other → SKIP.
  - HEXPRE: hex digit → HEX. Terminator → DONE with error. Other → SKIP.
  - DEC: decimal digit → accumulate. Terminator → DONE. Other → SKIP.
  - HEX: hex digit → accumulate. Terminator → DONE. Other → SKIP.
  - SKIP: consume bytes until a terminator → DONE with error.
  - DONE: hold outputs until res_rdy, then → IDLE.
- Accumulation:
  - Decimal: acc = acc*10 + d. This is computed at DW+4 bits. The sticky ovf flag is set if bits above DW-1 are nonzero; acc keeps the low DW bits.
  - Hex: ovf is set if acc[DW-1:DW-4] ≠ 0 before the step; acc = {acc[DW-5:0], d}.
  - Leading zeros never set ovf.
- Result on entry to DONE:
  - res_dat = neg ? -acc : acc, modulo 2^DW.
  - For negative values, ovf is also set if the magnitude exceeds 2^(DW-1).
  - On error: res_err = 1, res_dat = 0, res_ovf = 0.
- acc, ovf and neg clear on entry to IDLE.

## Timing

- Reset values:
  - rx_rdy = 0 during the reset cycle, 1 in the first cycle after.
  - res_vld = 0, res_dat = 0, res_ovf = 0, res_err = 0.
  - State = IDLE.
- rx_rdy = 1 in every state except DONE. This allows one character per cycle at full throughput.
- Latency: terminator accepted in cycle N → res_vld = 1 in cycle N+1, driven from registers.
- res_vld, res_dat, res_ovf and res_err stay stable while res_vld && !res_rdy.
- Handshake completes in cycle M → res_vld = 0 and rx_rdy = 1 in cycle M+1. There is no same-cycle turnaround.
- rx_dat is ignored when rx_vld = 0 or rx_rdy = 0.
- Reset mid-token or in DONE abandons the token with no result emitted. The next accepted byte starts a fresh token.
- The terminator that ends a token is consumed. Following terminators are skipped in IDLE.

## Test plan

- "1234 " at full rate, res_rdy = 1 → res_dat = 0x000004D2, ovf = 0, err = 0. res_vld pulses once, one cycle after the space is accepted.
- "0xDeadBeef\n" → 0xDEADBEEF, ovf = 0.
- "-42\0" → 0xFFFFFFD6.
- "-0x10 " → err = 1, res_dat = 0.
- "4294967296 " → ovf = 1, res_dat = 0x00000000.
- "0x1FFFFFFFF " → ovf = 1, res_dat = 0xFFFFFFFF.
- "-2147483648 " → 0x80000000, ovf = 0.
- "-2147483649 " → ovf = 1.
- "12a4 " then "  7\r" → first result err = 1, res_dat = 0. Second result = 7, err = 0.
- "0 " → 0, err = 0.
- "0x " → err = 1.
- "- " → err = 1.
- Backpressure: res_rdy held low 5 cycles after "99 ". rx_rdy stays 0 and result 99 is held stable. Release → one transfer, then rx_rdy = 1 the next cycle.
- rst asserted one cycle after "98" is consumed → no result emitted. Then "5 " → res_dat = 5.
